// File: rtl/serial_load_sequencer.sv
// Parallel-to-serial load sequencer: shifts a WIDTH-bit word out LSB-first,
// one bit slot every DIV clocks, with a one-clock en_out strobe per bit.
module serial_load_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             abort_in,
  output logic             ready_out,
  output logic             d_out,
  output logic             en_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh;
  logic [BW-1:0]    bcnt;
  logic [DW-1:0]    dcnt;

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) state <= IDLE;
    else              state <= state_nxt;
  end

  // Outputs decode registered state only; abort_in just gates the strobe.
  always_comb begin
    state_nxt = state;
    ready_out = 1'b0;
    busy_out  = 1'b0;
    d_out     = 1'b0;
    en_out    = 1'b0;
    done_out  = 1'b0;
    case (state)
      IDLE: begin
        ready_out = 1'b1;
        if (valid_in) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy_out = 1'b1;
        d_out    = sh[0];
        if (abort_in) begin
          state_nxt = IDLE;
        end else if (dcnt == DIV_LAST) begin
          en_out = 1'b1;
          if (bcnt == BIT_LAST) state_nxt = DONE;
        end
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      sh   <= '0;
      bcnt <= '0;
      dcnt <= '0;
    end else begin
      case (state)
        IDLE: if (valid_in) begin
          sh   <= data_in;
          bcnt <= '0;
          dcnt <= '0;
        end
        SHIFT: if (!abort_in) begin
          dcnt <= (dcnt == DIV_LAST) ? '0 : dcnt + DW'(1);
          if (en_out) begin
            sh   <= sh >> 1;
            bcnt <= bcnt + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_load_sequencer.sv
// Directed bench for serial_load_sequencer: a WIDTH=8/DIV=4 instance with a
// scoreboard-backed strobe monitor, plus a WIDTH=8/DIV=1 instance.
module tb_serial_load_sequencer;

  logic       clk = 1'b0;
  logic       reset_al_in;
  logic [7:0] data_in, data1;
  logic       valid_in, valid1, abort_in, abort1;
  logic       ready_out, d_out, en_out, busy_out, done_out;
  logic       ready1, dq1, en1, busy1, done1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_load_sequencer #(.WIDTH(8), .DIV(4)) dut (
    .clk(clk), .reset_al_in(reset_al_in), .data_in(data_in), .valid_in(valid_in),
    .abort_in(abort_in), .ready_out(ready_out), .d_out(d_out), .en_out(en_out),
    .busy_out(busy_out), .done_out(done_out));

  serial_load_sequencer #(.WIDTH(8), .DIV(1)) dut1 (
    .clk(clk), .reset_al_in(reset_al_in), .data_in(data1), .valid_in(valid1),
    .abort_in(abort1), .ready_out(ready1), .d_out(dq1), .en_out(en1),
    .busy_out(busy1), .done_out(done1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor for the DIV=4 instance; rel is the cycle index relative to the
  // most recent acceptance edge (cycle 0 ends at that edge).
  logic [7:0] sb[$];
  int         en_cyc[$], done_cyc[$], acc_rel[$];
  logic       en_bit[$];
  int         rel = 0, nstr = 0, rdy_cyc = -1;
  logic       rdy_seen = 1'b1;
  logic [7:0] recon = '0;

  always @(negedge clk) begin
    rel++;
    if (en_out) begin
      en_cyc.push_back(rel);
      en_bit.push_back(d_out);
      recon = {d_out, recon[7:1]};
      nstr++;
    end
    if (done_out) begin
      done_cyc.push_back(rel);
      if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
      else begin
        chk("sb_word", recon, sb.pop_front());
        chk("sb_nstrobe", nstr, 8);
      end
    end
    if (ready_out && !rdy_seen) begin
      rdy_cyc  = rel;
      rdy_seen = 1'b1;
    end
    if (valid_in && ready_out && reset_al_in) begin
      sb.push_back(data_in);
      acc_rel.push_back(rel);
      rel = 0; nstr = 0; recon = '0; rdy_seen = 1'b0;
    end
  end

  function automatic void clear_logs();
    en_cyc.delete(); done_cyc.delete(); acc_rel.delete(); en_bit.delete();
    rdy_cyc = -1;
  endfunction

  logic [7:0] w;
  logic [7:0] sb1[$];
  logic [7:0] recon1;

  initial begin
    reset_al_in = 1'b0;
    valid_in = 1'b1; data_in = 8'hA5; abort_in = 1'b0;
    valid1 = 1'b0; data1 = 8'h00; abort1 = 1'b0;
    #2;
    chk("reset_outs", {ready_out, busy_out, d_out, en_out, done_out}, 5'b10000);
    chk("reset_outs1", {ready1, busy1, dq1, en1, done1}, 5'b10000);

    // Frame 0xA5, accepted at the first edge after reset release
    clear_logs();
    tick(2);
    reset_al_in = 1'b1;
    tick(1);
    valid_in = 1'b0;
    @(negedge clk); #1;
    chk("a5_cycle1_outs", {ready_out, busy_out, d_out, en_out, done_out}, 5'b01100);
    tick(36);
    w = 8'hA5;
    chk("a5_en_count", en_cyc.size(), 8);
    for (int i = 0; i < 8 && i < en_cyc.size(); i++) begin
      chk("a5_en_cycle", en_cyc[i], 4 * (i + 1));
      chk("a5_d_bit", en_bit[i], w[i]);
    end
    chk("a5_done_count", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("a5_done_cycle", done_cyc[0], 33);
    chk("a5_ready_cycle", rdy_cyc, 34);

    // Abort in cycle 12; acceptance together with abort_in in IDLE
    clear_logs();
    valid_in = 1'b1; data_in = 8'h5A; abort_in = 1'b1;
    tick(1);
    valid_in = 1'b0; abort_in = 1'b0;
    chk("abort_idle_accepted", busy_out, 1'b1);
    tick(11);
    abort_in = 1'b1;
    @(negedge clk); #1;
    chk("abort_en_gated", {busy_out, en_out}, 2'b10);
    tick(1);
    abort_in = 1'b0;
    chk("abort_idle_c13", {ready_out, busy_out, done_out}, 3'b100);
    tick(5);
    chk("abort_en_count", en_cyc.size(), 2);
    if (en_cyc.size() == 2) begin
      chk("abort_en0", en_cyc[0], 4);
      chk("abort_en1", en_cyc[1], 8);
    end
    chk("abort_no_done", done_cyc.size(), 0);
    chk("abort_sb_pending", sb.size(), 1);
    sb.delete();

    // valid_in held across a frame: second word waits for cycle 34
    clear_logs();
    valid_in = 1'b1; data_in = 8'h01;
    tick(1);
    data_in = 8'hFF;
    tick(34);
    valid_in = 1'b0;
    chk("b2b_acc_count", acc_rel.size(), 2);
    if (acc_rel.size() == 2) chk("b2b_acc_cycle", acc_rel[1], 34);
    w = 8'h01;
    chk("b2b_first_bits", en_bit.size(), 8);
    for (int i = 0; i < 8 && i < en_bit.size(); i++) chk("b2b_d_bit", en_bit[i], w[i]);
    tick(36);
    chk("b2b_done_count", done_cyc.size(), 2);

    // Async reset between edges in cycle 10
    clear_logs();
    valid_in = 1'b1; data_in = 8'hC3;
    tick(1);
    valid_in = 1'b0;
    tick(9);
    #2;
    reset_al_in = 1'b0;
    #1;
    chk("rst_mid_outs", {ready_out, busy_out, d_out, en_out, done_out}, 5'b10000);
    tick(3);
    reset_al_in = 1'b1;
    tick(3);
    chk("rst_en_count", en_cyc.size(), 2);
    chk("rst_no_done", done_cyc.size(), 0);
    chk("rst_sb_pending", sb.size(), 1);
    sb.delete();

    // DIV=1: eight consecutive strobes, done in cycle 9, ready in cycle 10
    valid1 = 1'b1; data1 = 8'h3C;
    sb1.push_back(data1);
    recon1 = '0;
    w = 8'h3C;
    tick(1);
    valid1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); #1;
      chk("div1_en", en1, (c <= 8) ? 1'b1 : 1'b0);
      chk("div1_done", done1, (c == 9) ? 1'b1 : 1'b0);
      if (c <= 8) begin
        chk("div1_d_bit", dq1, w[c-1]);
        if (en1) recon1 = {dq1, recon1[7:1]};
      end
      if (c == 9 && sb1.size() > 0) chk("div1_sb_word", recon1, sb1.pop_front());
      if (c == 10) chk("div1_ready", ready1, 1'b1);
    end

    chk("sb_drained", sb.size() + sb1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_load_sequencer.md
SERIAL_LOAD_SEQUENCER -- requirements
Module: serial_load_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, bits per word; legal 2..32.
REQ-002 Parameter DIV, default 4, clocks per bit slot; legal 1..256.
REQ-003 The block SHALL provide port clk  input  1  single rising-edge clock for all state.
REQ-004 The block SHALL provide port reset_al_in  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL provide port data_in  input  WIDTH  parallel word to serialize.
REQ-006 The block SHALL provide port valid_in  input  1  data_in valid; transfer when valid_in and ready_out both high at a rising edge.
REQ-007 The block SHALL provide port abort_in  input  1  synchronous cancel of the frame in progress.
REQ-008 The block SHALL provide port ready_out  output  1  block can accept a word.
REQ-009 The block SHALL provide port d_out  output  1  serial data bit for downstream load-enable flops.
REQ-010 The block SHALL provide port en_out  output  1  one-clock load strobe qualifying d_out.
REQ-011 The block SHALL provide port busy_out  output  1  frame in progress.
REQ-012 The block SHALL provide port done_out  output  1  one-clock pulse on normal frame completion.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-014 IDLE: ready_out=1, busy_out=0, d_out=0, en_out=0, done_out=0.
REQ-015 IDLE with valid_in=1: at the edge, capture data_in into shift register, clear bit counter and divider counter, go to SHIFT.
REQ-016 SHIFT: ready_out=0, busy_out=1; divider counts 0..DIV-1 and wraps to 0.
REQ-017 SHIFT: en_out SHALL be 1 only in cycles where divider==DIV-1 and abort_in=0; zero-glitch, decoded from registered state only plus abort_in gating.
REQ-018 SHIFT: d_out SHALL equal shift register bit 0 (LSB-first) throughout the bit slot.
REQ-019 At each edge ending an en_out cycle: shift register shifts right by one, bit counter increments.
REQ-020 After the WIDTH-th en_out edge: go to DONE.
REQ-021 Timing (acceptance edge = cycle 0): en_out high in cycles k*DIV, k=1..WIDTH; done_out high in cycle WIDTH*DIV+1; ready_out high from cycle WIDTH*DIV+2.
REQ-022 DONE: done_out=1, busy_out=0, ready_out=0, en_out=0, d_out=0; unconditionally return to IDLE next edge.
REQ-023 DIV=1: en_out SHALL be high every SHIFT cycle, WIDTH consecutive pulses.
REQ-024 valid_in while not IDLE SHALL be ignored; data_in not sampled; no state change.
REQ-025 abort_in=1 in SHIFT: en_out forced 0 that cycle; next edge go to IDLE; no done_out; shift register contents don't-care.
REQ-026 abort_in in IDLE or DONE SHALL have no effect; abort_in and valid_in together in IDLE: word accepted.
REQ-027 Back-to-back frames: minimum spacing from one acceptance to the next is WIDTH*DIV+2 cycles.
REQ-028 Counters: bit counter width ceil(log2(WIDTH+1)), divider width ceil(log2(DIV)) minimum 1; no overflow at legal parameters.

Reset
REQ-029 reset_al_in=0 SHALL immediately, independent of clk, force state IDLE, shift register 0, both counters 0.
REQ-030 During reset: ready_out=1, busy_out=0, d_out=0, en_out=0, done_out=0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame with no further en_out or done_out.
REQ-032 First acceptance possible at the first rising edge with reset_al_in=1 and valid_in=1.

Verification
REQ-033 WIDTH=8, DIV=4, data_in=0xA5 accepted cycle 0 -> en_out cycles 4,8,...,32; d_out at strobes 1,0,1,0,0,1,0,1; done_out cycle 33; ready_out cycle 34.
REQ-034 DIV=1, WIDTH=8, data_in=0x3C -> 8 consecutive en_out cycles 1..8, d_out 0,0,1,1,1,1,0,0; done_out cycle 9.
REQ-035 WIDTH=8, DIV=4, abort_in=1 in cycle 12 -> en_out at 4,8 only, none at 12; IDLE at cycle 13; done_out never.
REQ-036 reset_al_in pulled low mid-cycle 10 of frame (between edges) -> outputs reach reset values before next clk edge; no done_out.
REQ-037 valid_in held 1 with data 0xFF during frame 0x01 -> second word accepted only at cycle 34; first frame d_out 1,0,0,0,0,0,0,0.
REQ-038 Scoreboard: strobe-sampled d_out into a d_ff bank with en_out as enable reconstructs every accepted word exactly.
